cajero_atm_ctrl: RTL and testbench

//  ATM session controller. Accepts a card, collects a 4-digit PIN and checks it against the card PIN.

---
 rtl/cajero_atm_if.sv | 35 +++
 rtl/cajero_atm_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cajero_atm_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cajero_atm_if.sv
// Signal bundle between the keypad/card front end (master) and the ATM session controller (slave).
interface cajero_atm_if;
    logic        tarjeta_recibida;
    logic [3:0]  digito;
    logic        digito_stb;
    logic [15:0] pin_correcto;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic [63:0] balance_inicial;

    logic [63:0] balance_actualizado;
    logic        balance_stb;
    logic        entregar_dinero;
    logic        fondos_insuficientes;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic [3:0]  estado_actual;
    logic [15:0] pin_ingresado_out;

    modport master (
        output tarjeta_recibida, digito, digito_stb, pin_correcto,
               tipo_trans, monto, monto_stb, balance_inicial,
        input  balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes,
               pin_incorrecto, advertencia, bloqueo, estado_actual, pin_ingresado_out
    );

    modport slave (
        input  tarjeta_recibida, digito, digito_stb, pin_correcto,
               tipo_trans, monto, monto_stb, balance_inicial,
        output balance_actualizado, balance_stb, entregar_dinero, fondos_insuficientes,
               pin_incorrecto, advertencia, bloqueo, estado_actual, pin_ingresado_out
    );
endinterface

// File: rtl/cajero_atm_ctrl.sv
// ATM session controller: card accept, 4-digit PIN check with lockout, one deposit/withdrawal.
// Define ATM_LIMITE_RETIRO_EN to also reject withdrawals above LIMITE_RETIRO.
module cajero_atm_ctrl #(
    parameter int unsigned MAX_INTENTOS = 3
`ifdef ATM_LIMITE_RETIRO_EN
    ,
    parameter logic [31:0] LIMITE_RETIRO = 32'd500000
`endif
) (
    input logic         clk,
    input logic         reset,
    cajero_atm_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StPin      = 4'd1,
        StVerif    = 4'd2,
        StTrans    = 4'd3,
        StDeposito = 4'd4,
        StRetiro   = 4'd5,
        StBloqueo  = 4'd6
    } estado_e;

    localparam int unsigned      IntW     = $clog2(MAX_INTENTOS + 1);
    localparam logic [IntW-1:0] IntMax   = IntW'(MAX_INTENTOS);
    localparam logic [IntW-1:0] IntAviso = IntW'(MAX_INTENTOS - 1);

    estado_e         estado;
    logic [15:0]     pin_q;
    logic [1:0]      digitos;
    logic [IntW-1:0] intentos;
    logic [63:0]     saldo_q;
    logic [31:0]     monto_q;

    // Result stage: DEPOSITO/RETIRO decide, the following edge publishes.
    logic            res_dep;
    logic            res_ok;
    logic            res_no;
    logic [63:0]     res_bal;

    logic [63:0]     bal_out;
    logic            balance_stb;
    logic            entregar;
    logic            fondos;
    logic            pin_inc;
    logic            advertencia;
    logic            bloqueo;

    logic [64:0]     suma;
    logic [63:0]     suma_sat;
    logic [63:0]     resta;
    logic            fondos_ok;
    logic            retiro_ok;
    logic            pin_ok;
    logic [IntW-1:0] intentos_mas;

    assign suma         = {1'b0, saldo_q} + {33'd0, monto_q};
    assign suma_sat     = suma[64] ? '1 : suma[63:0];
    assign resta        = saldo_q - {32'd0, monto_q};
    assign fondos_ok    = ({32'd0, monto_q} <= saldo_q);
    assign pin_ok       = (pin_q == bus.pin_correcto);
    assign intentos_mas = intentos + IntW'(1);

`ifdef ATM_LIMITE_RETIRO_EN
    assign retiro_ok = fondos_ok && (monto_q <= LIMITE_RETIRO);
`else
    assign retiro_ok = fondos_ok;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= StIdle;
            pin_q       <= '0;
            digitos     <= '0;
            intentos    <= '0;
            saldo_q     <= '0;
            monto_q     <= '0;
            res_dep     <= 1'b0;
            res_ok      <= 1'b0;
            res_no      <= 1'b0;
            res_bal     <= '0;
            bal_out     <= '0;
            balance_stb <= 1'b0;
            entregar    <= 1'b0;
            fondos      <= 1'b0;
            pin_inc     <= 1'b0;
            advertencia <= 1'b0;
            bloqueo     <= 1'b0;
        end else begin
            pin_inc     <= 1'b0;
            res_dep     <= 1'b0;
            res_ok      <= 1'b0;
            res_no      <= 1'b0;
            balance_stb <= res_dep | res_ok;
            entregar    <= res_ok;
            fondos      <= res_no;
            if (res_dep || res_ok) begin
                bal_out <= res_bal;
            end

            case (estado)
                StIdle: begin
                    if (bus.tarjeta_recibida) begin
                        saldo_q <= bus.balance_inicial;
                        pin_q   <= '0;
                        digitos <= '0;
                        estado  <= StPin;
                    end
                end
                StPin: begin
                    if (bus.digito_stb) begin
                        pin_q   <= {pin_q[11:0], bus.digito};
                        digitos <= digitos + 2'd1;
                        if (digitos == 2'd3) begin
                            estado <= StVerif;
                        end
                    end
                end
                StVerif: begin
                    if (pin_ok) begin
                        intentos    <= '0;
                        advertencia <= 1'b0;
                        estado      <= StTrans;
                    end else begin
                        pin_inc  <= 1'b1;
                        intentos <= intentos_mas;
                        if (intentos_mas == IntMax) begin
                            bloqueo <= 1'b1;
                            estado  <= StBloqueo;
                        end else begin
                            if (intentos_mas == IntAviso) begin
                                advertencia <= 1'b1;
                            end
                            pin_q   <= '0;
                            digitos <= '0;
                            estado  <= StPin;
                        end
                    end
                end
                StTrans: begin
                    if (bus.monto_stb) begin
                        monto_q <= bus.monto;
                        estado  <= bus.tipo_trans ? StRetiro : StDeposito;
                    end
                end
                StDeposito: begin
                    saldo_q <= suma_sat;
                    res_bal <= suma_sat;
                    res_dep <= 1'b1;
                    estado  <= StIdle;
                end
                StRetiro: begin
                    if (retiro_ok) begin
                        saldo_q <= resta;
                        res_bal <= resta;
                        res_ok  <= 1'b1;
                    end else begin
                        res_no <= 1'b1;
                    end
                    estado <= StIdle;
                end
                StBloqueo: begin
                    estado <= StBloqueo;
                end
                default: begin
                    estado <= StIdle;
                end
            endcase
        end
    end

    assign bus.balance_actualizado  = bal_out;
    assign bus.balance_stb          = balance_stb;
    assign bus.entregar_dinero      = entregar;
    assign bus.fondos_insuficientes = fondos;
    assign bus.pin_incorrecto       = pin_inc;
    assign bus.advertencia          = advertencia;
    assign bus.bloqueo              = bloqueo;
    assign bus.estado_actual        = estado;
    assign bus.pin_ingresado_out    = pin_q;

endmodule

// File: tb/tb_cajero_atm_ctrl.sv
// Scoreboard bench for cajero_atm_ctrl: directed scenarios then randomized sessions.
module tb_cajero_atm_ctrl;
    localparam int unsigned MAX      = 3;
    localparam logic [31:0] LIMIT    = 32'd500;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cajero_atm_if bus ();

    cajero_atm_ctrl #(
        .MAX_INTENTOS(MAX)
`ifdef ATM_LIMITE_RETIRO_EN
        ,
        .LIMITE_RETIRO(LIMIT)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef enum logic [1:0] {EvPinBad, EvDep, EvWdOk, EvWdNo} ev_kind_e;
    typedef struct {
        ev_kind_e    kind;
        logic [63:0] bal;
        logic        adv;
        logic        blq;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model of the account/session as seen from outside.
    int unsigned m_attempts = 0;
    logic        m_adv      = 1'b0;
    logic        m_locked   = 1'b0;
    logic [63:0] m_bal      = '0;
    logic [63:0] m_out      = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pulse_code(input ev_kind_e k);
        case (k)
            EvPinBad: pulse_code = 4'b1000;
            EvDep:    pulse_code = 4'b0100;
            EvWdOk:   pulse_code = 4'b0110;
            default:  pulse_code = 4'b0001;
        endcase
    endfunction

    task automatic push_ev(input ev_kind_e k, input logic [63:0] b, input logic a, input logic l);
        ev_t e;
        e.kind = k;
        e.bal  = b;
        e.adv  = a;
        e.blq  = l;
        expq.push_back(e);
    endtask

    // Monitor: pulses order = {pin_incorrecto, balance_stb, entregar_dinero, fondos_insuficientes}.
    logic [3:0] mon_pulses;
    ev_t        mon_ev;
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon_pulses = {bus.pin_incorrecto, bus.balance_stb, bus.entregar_dinero,
                          bus.fondos_insuficientes};
            if (mon_pulses != 4'b0000) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got pulses %b, required none (t=%0t)",
                             mon_pulses, $time);
                end else begin
                    mon_ev = expq.pop_front();
                    chk("pulses", 64'(mon_pulses), 64'(pulse_code(mon_ev.kind)));
                    chk("balance_actualizado", bus.balance_actualizado, mon_ev.bal);
                    chk("advertencia", 64'(bus.advertencia), 64'(mon_ev.adv));
                    chk("bloqueo", 64'(bus.bloqueo), 64'(mon_ev.blq));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tarjeta_recibida = 1'b0;
        bus.digito_stb       = 1'b0;
        bus.monto_stb        = 1'b0;
    endtask

    task automatic clear_model();
        m_attempts = 0;
        m_adv      = 1'b0;
        m_locked   = 1'b0;
        m_bal      = '0;
        m_out      = '0;
        expq.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_balance"}, bus.balance_actualizado, 64'd0);
        chk({tag, "_pulses"}, 64'({bus.pin_incorrecto, bus.balance_stb, bus.entregar_dinero,
                                   bus.fondos_insuficientes}), 64'd0);
        chk({tag, "_levels"}, 64'({bus.advertencia, bus.bloqueo}), 64'd0);
        chk({tag, "_estado"}, 64'(bus.estado_actual), 64'd0);
        chk({tag, "_pin"}, 64'(bus.pin_ingresado_out), 64'd0);
    endtask

    task automatic insert_card(input logic [63:0] b);
        bus.balance_inicial  = b;
        bus.tarjeta_recibida = 1'b1;
        step();
        bus.tarjeta_recibida = 1'b0;
        if (!m_locked) m_bal = b;
    endtask

    task automatic enter_pin(input logic [15:0] p, input logic [15:0] good, input bit noisy);
        for (int i = 0; i < 4; i++) begin
            if (noisy) begin
                int gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    bus.monto_stb  = 1'($urandom_range(0, 1));
                    bus.monto      = $urandom;
                    bus.tipo_trans = 1'($urandom_range(0, 1));
                    step();
                    bus.monto_stb = 1'b0;
                end
            end
            bus.digito     = p[15-4*i -: 4];
            bus.digito_stb = 1'b1;
            step();
            bus.digito_stb = 1'b0;
        end
        if (m_locked) return;
        if (p == good) begin
            m_attempts = 0;
            m_adv      = 1'b0;
            step();
            @(negedge clk);
            chk("pin_ingresado_out", 64'(bus.pin_ingresado_out), 64'(p));
            chk("estado_trans", 64'(bus.estado_actual), 64'd3);
        end else begin
            m_attempts++;
            if (m_attempts == MAX) m_locked = 1'b1;
            else if (m_attempts == MAX - 1) m_adv = 1'b1;
            push_ev(EvPinBad, m_out, m_adv, m_locked);
            step();
        end
    endtask

    task automatic transaction(input bit tipo, input logic [31:0] m, input bit noisy);
        logic [63:0] nb;
        logic        ok;
        bus.tipo_trans = tipo;
        bus.monto      = m;
        bus.monto_stb  = 1'b1;
        if (noisy) begin
            bus.digito_stb = 1'b1;
            bus.digito     = 4'($urandom);
        end
        step();
        bus.monto_stb  = 1'b0;
        bus.digito_stb = 1'b0;
        if (!tipo) begin
            if (ALL_ONES - m_bal < 64'(m)) nb = ALL_ONES;
            else nb = m_bal + 64'(m);
            m_bal = nb;
            m_out = nb;
            push_ev(EvDep, nb, m_adv, 1'b0);
        end else begin
            ok = (64'(m) <= m_bal);
`ifdef ATM_LIMITE_RETIRO_EN
            ok = ok && (m <= LIMIT);
`endif
            if (ok) begin
                m_bal = m_bal - 64'(m);
                m_out = m_bal;
                push_ev(EvWdOk, m_out, m_adv, 1'b0);
            end else begin
                push_ev(EvWdNo, m_out, m_adv, 1'b0);
            end
        end
        step();
        @(negedge clk);
        chk("latency_early", 64'({bus.balance_stb, bus.entregar_dinero,
                                  bus.fondos_insuficientes}), 64'd0);
        step();
        @(negedge clk);
        chk("latency_on_time", 64'(bus.balance_stb | bus.fondos_insuficientes), 64'd1);
        step();
        chk("estado_idle", 64'(bus.estado_actual), 64'd0);
    endtask

    task automatic ignored_stim();
        for (int i = 0; i < 6; i++) begin
            bus.tarjeta_recibida = 1'b1;
            bus.digito_stb       = 1'b1;
            bus.digito           = 4'(i);
            bus.monto_stb        = 1'b1;
            bus.tipo_trans       = 1'(i);
            bus.monto            = 32'(i);
            step();
        end
        idle_inputs();
        step();
        @(negedge clk);
        chk("estado_bloqueo", 64'(bus.estado_actual), 64'd6);
        chk("bloqueo_level", 64'(bus.bloqueo), 64'd1);
    endtask

    initial begin
        logic [63:0] b;
        logic [15:0] good;
        logic [15:0] p;
        logic [31:0] m;
        bit          done;

        idle_inputs();
        bus.digito          = '0;
        bus.pin_correcto    = '0;
        bus.tipo_trans      = 1'b0;
        bus.monto           = '0;
        bus.balance_inicial = '0;

        apply_reset();
        @(negedge clk);
        check_zero("reset");

        bus.pin_correcto = 16'h1234;
        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b0, 32'd500, 1'b0);

        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b1, 32'd300, 1'b0);

        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b1, 32'd2000, 1'b0);

        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b1, 32'd1000, 1'b0);

`ifdef ATM_LIMITE_RETIRO_EN
        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b1, 32'd600, 1'b0);
        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b1, 32'd500, 1'b0);
`endif

        insert_card(ALL_ONES - 64'd10);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        transaction(1'b0, 32'd100, 1'b1);

        // Reset while waiting for an amount in TRANS.
        insert_card(64'd1000);
        enter_pin(16'h1234, 16'h1234, 1'b0);
        reset = 1'b1;
        step();
        @(negedge clk);
        check_zero("reset_in_trans");
        reset = 1'b0;
        clear_model();

        insert_card(64'd5000);
        enter_pin(16'h1111, 16'h1234, 1'b0);
        @(negedge clk);
        chk("adv_after_1st", 64'(bus.advertencia), 64'd0);
        enter_pin(16'h1111, 16'h1234, 1'b0);
        @(negedge clk);
        chk("adv_after_2nd", 64'(bus.advertencia), 64'd1);
        enter_pin(16'h1111, 16'h1234, 1'b0);
        @(negedge clk);
        chk("bloqueo_after_3rd", 64'(bus.bloqueo), 64'd1);
        chk("estado_after_3rd", 64'(bus.estado_actual), 64'd6);
        ignored_stim();
        apply_reset();
        @(negedge clk);
        check_zero("reset_after_lock");

        for (int s = 0; s < 150; s++) begin
            good = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 64'($urandom_range(0, 5000));
                1:       b = {$urandom, $urandom};
                2:       b = ALL_ONES - 64'($urandom_range(0, 3000));
                default: b = 64'($urandom_range(0, 1000000));
            endcase
            bus.pin_correcto = good;
            insert_card(b);
            done = 1'b0;
            while (!done) begin
                if ($urandom_range(0, 1) == 0) p = good;
                else p = 16'($urandom);
                enter_pin(p, good, 1'b1);
                done = m_locked || (p == good);
            end
            if (m_locked) begin
                ignored_stim();
                apply_reset();
                @(negedge clk);
                check_zero("rand_reset");
            end else begin
                case ($urandom_range(0, 2))
                    0:       m = 32'($urandom_range(0, 6000));
                    1:       m = $urandom;
                    default: m = (b[63:32] == 32'd0) ? b[31:0] : 32'($urandom_range(0, 900));
                endcase
                transaction(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)));
            end
        end

        repeat (5) step();
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
